// File: rtl/cop_mem_model.sv
// cop_mem_model: reference memory responder for the COP memory interface.
//
// A small word-addressed memory that answers one request at a time. Each
// accepted request may be held off for 0..3 cycles (stall_len) before its
// completion cycle. In the completion cycle the read data / error are
// presented. A write commits at the completion edge. Requester protocol
// violations (dropping or changing a request while stalled) are latched in
// a sticky flag.
//
// Ports:
//   g_clk, g_reset        clock, synchronous active-high reset
//   cop_mem_cen/wen       request enable, write enable
//   cop_mem_addr/wdata    byte address (word aligned), write data
//   cop_mem_ben           write byte enables
//   stall_len, err_inj    per-request stall length and forced error (sampled on accept)
//   cop_mem_rdata/error   completion-cycle read data and error
//   cop_mem_stall         response not ready; requester holds its request
//   proto_violation       sticky requester protocol violation
module cop_mem_model #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  input  logic [1:0]  stall_len,
  input  logic        err_inj,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  output logic        proto_violation
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                     state;
  logic [1:0]                 cnt;
  logic [31:0]                addr_q;
  logic                       wen_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 ben_q;
  logic                       err_q;
  logic [DEPTH-1:0][31:0]     mem;

  logic                       done;
  logic                       accept;
  logic                       req_err;
  logic                       req_changed;
  logic [DEPTH_LOG2-1:0]      idx;

  // Stall and completion are decoded purely from registered state, so the
  // requester never sees a combinational path from its own inputs.
  assign cop_mem_stall = (state == WAIT) && (cnt != 2'd0);
  assign done          = (state == WAIT) && (cnt == 2'd0);
  assign accept        = cop_mem_cen && !cop_mem_stall;
  assign idx           = addr_q[DEPTH_LOG2+1:2];

  // Misaligned or beyond the last word is an error, as is a forced error.
  assign req_err = err_inj || (cop_mem_addr[1:0] != 2'b00) ||
                   (cop_mem_addr[31:DEPTH_LOG2+2] != '0);

  assign req_changed = !cop_mem_cen || (cop_mem_addr != addr_q) ||
                       (cop_mem_wen != wen_q) || (cop_mem_wdata != wdata_q) ||
                       (cop_mem_ben != ben_q);

  // Read data reflects memory before this request's own write commits.
  assign cop_mem_rdata = (done && !err_q) ? mem[idx] : 32'd0;
  assign cop_mem_error = done && err_q;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state           <= IDLE;
      cnt             <= 2'd0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      ben_q           <= '0;
      err_q           <= 1'b0;
      proto_violation <= 1'b0;
      mem             <= '0;
    end else begin
      if (cop_mem_stall && req_changed)
        proto_violation <= 1'b1;

      if (done && wen_q && !err_q) begin
        for (int b = 0; b < 4; b++)
          if (ben_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end

      // Acceptance also happens in the completion cycle (back-to-back).
      if (accept) begin
        state   <= WAIT;
        cnt     <= stall_len;
        addr_q  <= cop_mem_addr;
        wen_q   <= cop_mem_wen;
        wdata_q <= cop_mem_wdata;
        ben_q   <= cop_mem_ben;
        err_q   <= req_err;
      end else if (cop_mem_stall) begin
        cnt <= cnt - 2'd1;
      end else if (done) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cop_mem_model.sv
module tb_cop_mem_model;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        cop_mem_cen;
  logic        cop_mem_wen;
  logic [31:0] cop_mem_addr;
  logic [31:0] cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [1:0]  stall_len;
  logic        err_inj;
  logic [31:0] cop_mem_rdata;
  logic        cop_mem_stall;
  logic        cop_mem_error;
  logic        proto_violation;

  int n_vec  = 0;
  int n_fail = 0;

  cop_mem_model #(.DEPTH_LOG2(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen),
    .cop_mem_addr(cop_mem_addr), .cop_mem_wdata(cop_mem_wdata),
    .cop_mem_ben(cop_mem_ben), .stall_len(stall_len), .err_inj(err_inj),
    .cop_mem_rdata(cop_mem_rdata), .cop_mem_stall(cop_mem_stall),
    .cop_mem_error(cop_mem_error), .proto_violation(proto_violation)
  );

  always #5 g_clk = ~g_clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Transaction-level reference: one outstanding request with a count of
  // stall cycles still to go. Its response is fixed when it is accepted,
  // after the previous write has landed.
  logic [31:0] mmem [16];
  bit          pend   = 0;
  bit          mvalid = 0;
  bit          viol   = 0;
  int          left   = 0;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic        r_wen, r_err;
  logic [3:0]  r_ben;

  initial begin
    forever begin
      @(negedge g_clk);
      if (mvalid) begin
        chk("m_stall", {31'd0, cop_mem_stall}, {31'd0, pend && left > 0});
        chk("m_error", {31'd0, cop_mem_error}, {31'd0, pend && left == 0 && r_err});
        chk("m_rdata", cop_mem_rdata, (pend && left == 0) ? r_rd : 32'd0);
        chk("m_proto", {31'd0, proto_violation}, {31'd0, viol});
      end
      if (g_reset) begin
        for (int i = 0; i < 16; i++) mmem[i] = 32'd0;
        pend = 0; left = 0; viol = 0; mvalid = 1;
      end else if (mvalid) begin
        if (pend && left > 0) begin
          if (!cop_mem_cen || cop_mem_addr != r_addr || cop_mem_wen != r_wen ||
              cop_mem_wdata != r_wdata || cop_mem_ben != r_ben) viol = 1;
          left--;
        end else begin
          if (pend && r_wen && !r_err)
            for (int b = 0; b < 4; b++)
              if (r_ben[b]) mmem[r_addr[5:2]][8*b +: 8] = r_wdata[8*b +: 8];
          if (cop_mem_cen) begin
            pend    = 1;
            left    = int'(stall_len);
            r_addr  = cop_mem_addr;
            r_wen   = cop_mem_wen;
            r_wdata = cop_mem_wdata;
            r_ben   = cop_mem_ben;
            r_err   = err_inj || cop_mem_addr[1:0] != 2'b00 || cop_mem_addr[31:2] >= 30'd16;
            r_rd    = r_err ? 32'd0 : mmem[cop_mem_addr[5:2]];
          end else begin
            pend = 0;
          end
        end
      end
    end
  end

  // One isolated request from IDLE; returns completion-cycle outputs and
  // the number of stalled cycles seen.
  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] b, input logic [1:0] sl, input logic ei,
                     output logic [31:0] rd, output logic er, output int ns);
    cop_mem_cen = 1'b1; cop_mem_wen = w; cop_mem_addr = a; cop_mem_wdata = d;
    cop_mem_ben = b; stall_len = sl; err_inj = ei;
    @(posedge g_clk); #1;
    ns = 0;
    while (cop_mem_stall && ns < 8) begin
      ns++;
      @(posedge g_clk); #1;
    end
    if (cop_mem_stall) chk("stall_timeout", {31'd0, cop_mem_stall}, 32'd0);
    rd = cop_mem_rdata; er = cop_mem_error;
    cop_mem_cen = 1'b0; cop_mem_wen = 1'b0; stall_len = 2'd0; err_inj = 1'b0;
    @(posedge g_clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          ns;

  initial begin
    g_reset = 1'b1; cop_mem_cen = 1'b0; cop_mem_wen = 1'b0; cop_mem_addr = '0;
    cop_mem_wdata = '0; cop_mem_ben = '0; stall_len = '0; err_inj = 1'b0;
    repeat (2) @(posedge g_clk);
    #1 g_reset = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 5; i++) begin
      chk("idle_out", {cop_mem_rdata[29:0], cop_mem_stall, cop_mem_error}, 32'd0);
      chk("idle_proto", {31'd0, proto_violation}, 32'd0);
      @(posedge g_clk); #1;
    end

    // Full write, then a read with two stall cycles.
    req(32'h8, 1'b1, 32'hDEADBEEF, 4'hF, 2'd0, 1'b0, rd, er, ns);
    chk("wr8_err", {31'd0, er}, 32'd0);
    req(32'h8, 1'b0, 32'h0, 4'h0, 2'd2, 1'b0, rd, er, ns);
    chk("rd8_stalls", ns, 32'd2);
    chk("rd8_data", rd, 32'hDEADBEEF);
    chk("rd8_err", {31'd0, er}, 32'd0);

    // Byte-lane write.
    req(32'h8, 1'b1, 32'h000000AA, 4'h1, 2'd0, 1'b0, rd, er, ns);
    req(32'h8, 1'b0, 32'h0, 4'h0, 2'd1, 1'b0, rd, er, ns);
    chk("rd8_ben", rd, 32'hDEADBEAA);

    // Error responses: out of range, misaligned, injected on a write.
    req(32'h40, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, rd, er, ns);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_data", rd, 32'd0);
    req(32'h6, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, rd, er, ns);
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_data", rd, 32'd0);
    req(32'h4, 1'b1, 32'h12345678, 4'hF, 2'd3, 1'b1, rd, er, ns);
    chk("inj_err", {31'd0, er}, 32'd1);
    chk("inj_data", rd, 32'd0);
    req(32'h4, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, rd, er, ns);
    chk("rd4_after_inj", rd, 32'd0);
    chk("rd4_after_inj_err", {31'd0, er}, 32'd0);
    req(32'h0, 1'b1, 32'h0BADF00D, 4'hF, 2'd0, 1'b0, rd, er, ns);

    // Back-to-back with cen held: write 4, then read 4 (sees new data), 0, 8.
    cop_mem_cen = 1'b1; cop_mem_wen = 1'b1; cop_mem_addr = 32'h4;
    cop_mem_wdata = 32'hCAFEF00D; cop_mem_ben = 4'hF; stall_len = 2'd0;
    @(posedge g_clk); #1;
    chk("b2b_wr_stall", {31'd0, cop_mem_stall}, 32'd0);
    cop_mem_wen = 1'b0; cop_mem_addr = 32'h4;
    @(posedge g_clk); #1;
    chk("b2b_raw_stall", {31'd0, cop_mem_stall}, 32'd0);
    chk("b2b_raw_data", cop_mem_rdata, 32'hCAFEF00D);
    cop_mem_addr = 32'h0;
    @(posedge g_clk); #1;
    chk("b2b_rd0_stall", {31'd0, cop_mem_stall}, 32'd0);
    chk("b2b_rd0_data", cop_mem_rdata, 32'h0BADF00D);
    cop_mem_addr = 32'h8;
    @(posedge g_clk); #1;
    chk("b2b_rd8_stall", {31'd0, cop_mem_stall}, 32'd0);
    chk("b2b_rd8_data", cop_mem_rdata, 32'hDEADBEAA);
    cop_mem_cen = 1'b0;
    @(posedge g_clk); #1;
    chk("b2b_idle", {cop_mem_rdata[30:0], cop_mem_error}, 32'd0);

    // Protocol violation during a stall, then reset mid-stall.
    cop_mem_cen = 1'b1; cop_mem_addr = 32'h0; stall_len = 2'd3;
    @(posedge g_clk); #1;
    chk("pv_stall", {31'd0, cop_mem_stall}, 32'd1);
    chk("pv_before", {31'd0, proto_violation}, 32'd0);
    cop_mem_addr = 32'h4;
    @(posedge g_clk); #1;
    chk("pv_set", {31'd0, proto_violation}, 32'd1);
    cop_mem_addr = 32'h0;
    @(posedge g_clk); #1;
    chk("pv_held", {31'd0, proto_violation}, 32'd1);
    chk("pv_still_stall", {31'd0, cop_mem_stall}, 32'd1);
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0; cop_mem_cen = 1'b0; stall_len = 2'd0;
    chk("rst_stall", {31'd0, cop_mem_stall}, 32'd0);
    chk("rst_error", {31'd0, cop_mem_error}, 32'd0);
    chk("rst_rdata", cop_mem_rdata, 32'd0);
    chk("rst_proto", {31'd0, proto_violation}, 32'd0);
    req(32'h8, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, rd, er, ns);
    chk("rst_mem8", rd, 32'd0);
    req(32'h0, 1'b0, 32'h0, 4'h0, 2'd1, 1'b0, rd, er, ns);
    chk("rst_mem0", rd, 32'd0);

    repeat (2) @(posedge g_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cop_mem_model.md
# cop_mem_model

Synthesizable reference memory responder for the COP memory interface, used in simulation and formal benches. Sits directly downstream of the COP memory port and drives `cop_mem_rdata`, `cop_mem_stall` and `cop_mem_error`, producing exactly the request/stall/finish/error pattern the formal transaction-capture logic tracks. It contains a small word-addressed register memory, a programmable per-request stall counter, error generation, and a sticky flag for requester protocol violations.

## Interface

Parameters:
- `DEPTH_LOG2`, 4, log2 of the number of 32-bit words (default 16 words).

Ports:
- `g_clk`  in  1  global clock.
- `g_reset`  in  1  synchronous, active-high reset.
- `cop_mem_cen`  in  1  request / chip enable.
- `cop_mem_wen`  in  1  write enable.
- `cop_mem_addr`  in  32  byte address; must be word aligned.
- `cop_mem_wdata`  in  32  write data.
- `cop_mem_ben`  in  4  write byte enables; bit i covers wdata[8i+7:8i].
- `stall_len`  in  2  stall cycles for the request accepted this cycle (0..3). Driven by the bench, or left free in formal.
- `err_inj`  in  1  forces an error response for the request accepted this cycle.
- `cop_mem_rdata`  out  32  read data; valid in the completion cycle.
- `cop_mem_stall`  out  1  response not ready; requester must hold its request.
- `cop_mem_error`  out  1  error response; valid in the completion cycle.
- `proto_violation`  out  1  sticky requester protocol violation.

## Operation

- States: IDLE, WAIT. Registers: `cnt[1:0]`, latched `addr`, `wen`, `wdata`, `ben`, `err`.
- Acceptance: on an edge with `cop_mem_cen`=1 and `cop_mem_stall`=0, the block latches the request fields.
  - `cnt` is loaded with `stall_len`.
  - `err` is loaded with `err_inj`, OR `addr[1:0]`≠0, OR `addr[31:2]` ≥ 2^DEPTH_LOG2.
  - The state goes to WAIT.
- `cop_mem_stall` = (state==WAIT && cnt≠0). This is a registered-state decode with no combinational path from the inputs.
- In WAIT with cnt≠0, each edge decrements `cnt`.
- Completion cycle: WAIT with cnt==0. Stall is low in this cycle.
  - `cop_mem_rdata` = mem[latched addr] (pre-write contents), or 0 if `err`.
  - `cop_mem_error` = `err`.
- At the completion edge:
  - A write with `err`=0 commits each enabled byte.
  - An erroring write commits nothing.
  - If `cop_mem_cen`=1, a new request is accepted on the same edge (back-to-back). Otherwise the state returns to IDLE.
- Outside the completion cycle, `cop_mem_rdata`=0 and `cop_mem_error`=0. Therefore error is only ever asserted in a cycle whose previous cycle had `cen`=1.
- Protocol violation: `proto_violation` is set and held until reset if, while `cop_mem_stall`=1, either of the following holds:
  - `cop_mem_cen`=0;
  - `addr`, `wen`, `wdata` or `ben` differ from the latched values.
- Reset, including mid-operation:
  - All outputs go to 0, the state to IDLE, `cnt` to 0.
  - All memory words go to 0.
  - A pending write is discarded.

## Timing

- Minimum latency: request accepted at edge T; completion cycle is T+1.
- Maximum latency: T+1+3 (stall_len=3, stall high for 3 cycles).
- Throughput: one request per cycle when stall_len=0 and `cen` is held high.
- Read-after-write to the same word, back-to-back: the second request completes at least one cycle after the first write commits, so it returns the new data. No forwarding path is required.
- `cen`=0 during a completion cycle: no new request; the next cycle is IDLE with all outputs low.
- `stall_len` and `err_inj` are sampled only at acceptance edges and ignored otherwise.
- Reset asserted in any cycle takes priority over acceptance, completion and writes.

## Test plan

- Reset, then idle 5 cycles → stall, error, rdata and proto_violation stay 0.
- Write 0xDEADBEEF to addr 0x8, ben=0xF, stall_len=0; then read 0x8 with stall_len=2:
  - the read's stall is high for 2 cycles;
  - its completion cycle returns 0xDEADBEEF with error=0.
- Write 0x000000AA to addr 0x8, ben=0x1; then read 0x8 → 0xDEADBEAA.
- Read addr 0x40 (out of range for 16 words), then addr 0x6 (misaligned), then a write to 0x4 with err_inj=1:
  - each completes with error=1 and rdata=0;
  - a subsequent read of 0x4 returns 0.
- Back-to-back reads of 0x0, 0x4, 0x8 with cen held high and stall_len=0 → three consecutive completion cycles, stall never high.
- During a stall (stall_len=3), change addr → proto_violation=1 and held. Then assert g_reset mid-stall → all outputs 0 next cycle, memory cleared.
